// File: rtl/gpio_bidir_irq_if.sv
// Control/status bundle for the GPIO pad block: pad drive/direction, debounce setup,
// edge-interrupt enables and sticky status readback.
interface gpio_bidir_irq_if #(
  parameter int WIDTH = 16,
  parameter int DB_W  = 8
);
  logic [WIDTH-1:0] din_i;
  logic [WIDTH-1:0] in_not_out_i;
  logic [WIDTH-1:0] dout_o;
  logic [WIDTH-1:0] db_en_i;
  logic [DB_W-1:0]  db_limit_i;
  logic [WIDTH-1:0] rise_en_i;
  logic [WIDTH-1:0] fall_en_i;
  logic [WIDTH-1:0] irq_clr_i;
  logic [WIDTH-1:0] irq_status_o;
  logic             irq_o;

  modport master (
    output din_i, in_not_out_i, db_en_i, db_limit_i, rise_en_i, fall_en_i, irq_clr_i,
    input  dout_o, irq_status_o, irq_o
  );

  modport slave (
    input  din_i, in_not_out_i, db_en_i, db_limit_i, rise_en_i, fall_en_i, irq_clr_i,
    output dout_o, irq_status_o, irq_o
  );
endinterface

// File: rtl/gpio_bidir_irq.sv
// Tri-state GPIO pads with input synchroniser, per-channel debounce filter and
// sticky rising/falling edge interrupt status.
module gpio_bidir_irq #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2,
  parameter int DB_W        = 8
) (
  input  logic             HCLK,
  input  logic             HRESETn,
  inout  wire [WIDTH-1:0]  dio_buf,
  gpio_bidir_irq_if.slave  bus
);

  localparam int SC_W = (SYNC_STAGES + 1 > 2) ? $clog2(SYNC_STAGES + 1) : 1;

  typedef enum logic {
    ST_STARTUP,
    ST_RUN
  } state_t;

  state_t            state_q, state_d;
  logic [SC_W-1:0]   st_cnt_q, st_cnt_d;
  logic              startup;

  logic [WIDTH-1:0]  sync_q [SYNC_STAGES];
  logic [WIDTH-1:0]  sync;
  logic [WIDTH-1:0]  filt_q, filt_d;
  logic [DB_W-1:0]   cnt_q [WIDTH];
  logic [DB_W-1:0]   cnt_d [WIDTH];
  logic [WIDTH-1:0]  status_q, status_d;
  logic [WIDTH-1:0]  rise_ev, fall_ev;

  for (genvar g = 0; g < WIDTH; g++) begin : g_pad
    assign dio_buf[g] = bus.in_not_out_i[g] ? 1'bz : bus.din_i[g];
  end

  assign sync             = sync_q[SYNC_STAGES-1];
  assign bus.dout_o       = filt_q;
  assign bus.irq_status_o = status_q;
  assign bus.irq_o        = |status_q;

  // Startup window covers the edges where the synchroniser fills and filt first loads.
  always_comb begin
    state_d  = state_q;
    st_cnt_d = st_cnt_q;
    startup  = 1'b0;
    case (state_q)
      ST_STARTUP: begin
        startup = 1'b1;
        if (st_cnt_q == SC_W'(SYNC_STAGES)) begin
          state_d  = ST_RUN;
          st_cnt_d = '0;
        end else begin
          st_cnt_d = st_cnt_q + SC_W'(1);
        end
      end
      ST_RUN: begin
        startup = 1'b0;
      end
      default: begin
        state_d  = ST_STARTUP;
        st_cnt_d = '0;
      end
    endcase
  end

  always_comb begin
    filt_d = filt_q;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      cnt_d[i] = cnt_q[i];
      if (startup || !bus.db_en_i[i]) begin
        filt_d[i] = sync[i];
        cnt_d[i]  = '0;
      end else if (sync[i] == filt_q[i]) begin
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= bus.db_limit_i) begin
        filt_d[i] = sync[i];
        cnt_d[i]  = '0;
      end else begin
        cnt_d[i] = cnt_q[i] + DB_W'(1);
      end
    end
    rise_ev  = startup ? '0 : (~filt_q &  filt_d & bus.rise_en_i);
    fall_ev  = startup ? '0 : ( filt_q & ~filt_d & bus.fall_en_i);
    // Set has priority over write-1-to-clear.
    status_d = rise_ev | fall_ev | (status_q & ~bus.irq_clr_i);
  end

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_STARTUP;
      st_cnt_q <= '0;
      filt_q   <= '0;
      status_q <= '0;
      for (int unsigned s = 0; s < SYNC_STAGES; s++) sync_q[s] <= '0;
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      state_q   <= state_d;
      st_cnt_q  <= st_cnt_d;
      filt_q    <= filt_d;
      status_q  <= status_d;
      sync_q[0] <= dio_buf;
      for (int unsigned s = 1; s < SYNC_STAGES; s++) sync_q[s] <= sync_q[s-1];
      for (int unsigned i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end

endmodule
